// File: rtl/text_cell_fetch.sv
// text_cell_fetch: character-cell front end of the VGA text path.
// It owns the screen character RAM, which holds one byte per cell.
// On the scanout side it maps hc/vc to a cell and returns the char code and the
// pixel offset inside the cell, two clocks after hc/vc are presented.
// On the host side it takes characters at an auto-advancing cursor and can
// bulk-clear the screen.
// Optional feature: define CURSOR_BLINK_EN to enable the blinking cursor
// highlight on cur_hit. When it is undefined, cur_hit is tied to 0.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | host port open (wr_ready=1), chars handled one per clock
//   ST_CLEAR | writing FILL to every cell, one per clock; host port closed
module text_cell_fetch #(
   parameter int          COLS     = 160,
   parameter int          ROWS     = 60,
   parameter int          CELL_W   = 4,
   parameter int          CELL_H   = 8,
   parameter int          HBP      = 144,
   parameter int          VBP      = 31,
   parameter int          ACT_W    = 640,
   parameter int          ACT_H    = 480,
   parameter logic [7:0]  FILL     = 8'h20,
   parameter int          BLINK_FR = 16
) (
   input  logic                        clk,
   input  logic                        clr_n,
   input  logic [9:0]                  hc,
   input  logic [9:0]                  vc,
   input  logic                        wr_valid,
   input  logic [7:0]                  wr_char,
   output logic                        wr_ready,
   input  logic                        clear_req,
   output logic                        busy,
   output logic [$clog2(COLS)-1:0]     cur_x,
   output logic [$clog2(ROWS)-1:0]     cur_y,
   output logic [7:0]                  char_code,
   output logic [$clog2(CELL_W)-1:0]   cell_px,
   output logic [$clog2(CELL_H)-1:0]   cell_py,
   output logic                        pix_act,
   output logic                        cur_hit
);

   localparam int NCELL = COLS * ROWS;
   localparam int AW    = $clog2(NCELL);
   localparam int XW    = $clog2(COLS);
   localparam int YW    = $clog2(ROWS);
   localparam int PXW   = $clog2(CELL_W);
   localparam int PYW   = $clog2(CELL_H);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   // The multiply by COLS is built from shifts and adds, one term per set bit of COLS.
   function automatic logic [AW-1:0] f_addr(input logic [YW-1:0] y, input logic [XW-1:0] x);
      logic [AW-1:0] acc;
      acc = AW'(x);
      for (int i = 0; i < AW; i++)
         if (COLS[i]) acc = acc + (AW'(y) << i);
      return acc;
   endfunction

   state_t            r_state;
   logic              r_rdy;
   logic              r_busy;
   logic [AW-1:0]     r_clr_addr;
   logic [XW-1:0]     r_cur_x;
   logic [YW-1:0]     r_cur_y;

   logic [7:0]        r_mem [NCELL];

   logic              r_s1_act;
   logic [AW-1:0]     r_s1_addr;
   logic [PXW-1:0]    r_s1_px;
   logic [PYW-1:0]    r_s1_py;
   logic [7:0]        r_char_code;
   logic [PXW-1:0]    r_cell_px;
   logic [PYW-1:0]    r_cell_py;
   logic              r_pix_act;

   logic              w_act;
   logic [PXW+XW-1:0] w_px;
   logic [PYW+YW-1:0] w_py;
   logic [XW-1:0]     w_col;
   logic [YW-1:0]     w_row;
   logic              w_accept;
   logic [YW-1:0]     w_y_inc;
   logic              w_we;
   logic [AW-1:0]     w_waddr;
   logic [7:0]        w_wdata;

   assign w_act = (hc >= 10'(HBP)) && (hc < 10'(HBP + ACT_W)) &&
                  (vc >= 10'(VBP)) && (vc < 10'(VBP + ACT_H));
   assign w_px  = (PXW+XW)'(hc - 10'(HBP));
   assign w_py  = (PYW+YW)'(vc - 10'(VBP));
   assign w_col = w_px[PXW +: XW];
   assign w_row = w_py[PYW +: YW];

   // A clear request closes the port in the same cycle, so a colliding write is never handshaken.
   assign wr_ready = r_rdy & ~clear_req;
   assign w_accept = wr_valid & wr_ready & (r_state == ST_IDLE);
   assign w_y_inc  = (r_cur_y == YW'(ROWS - 1)) ? '0 : r_cur_y + 1'b1;

   // The clear sequencer and the cursor update in one state machine.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state    <= ST_IDLE;
         r_rdy      <= 1'b0;
         r_busy     <= 1'b0;
         r_clr_addr <= '0;
         r_cur_x    <= '0;
         r_cur_y    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rdy <= 1'b1;
               if (clear_req) begin
                  r_state    <= ST_CLEAR;
                  r_rdy      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_clr_addr <= '0;
               end else if (w_accept) begin
                  case (wr_char)
                     8'h0A: begin
                        r_cur_x <= '0;
                        r_cur_y <= w_y_inc;
                     end
                     8'h08: begin
                        if (r_cur_x != '0) r_cur_x <= r_cur_x - 1'b1;
                     end
                     default: begin
                        if (r_cur_x == XW'(COLS - 1)) begin
                           r_cur_x <= '0;
                           r_cur_y <= w_y_inc;
                        end else begin
                           r_cur_x <= r_cur_x + 1'b1;
                        end
                     end
                  endcase
               end
            end
            ST_CLEAR: begin
               if (r_clr_addr == AW'(NCELL - 1)) begin
                  r_state <= ST_IDLE;
                  r_rdy   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_cur_x <= '0;
                  r_cur_y <= '0;
               end else begin
                  r_clr_addr <= r_clr_addr + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Select the write-port source: the clear sweep, or a printable host char at the cursor.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = f_addr(r_cur_y, r_cur_x);
      w_wdata = wr_char;
      if (r_state == ST_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = r_clr_addr;
         w_wdata = FILL;
      end else if (w_accept && (wr_char != 8'h0A) && (wr_char != 8'h08)) begin
         w_we = 1'b1;
      end
   end

   // RAM write port. The contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   // Scanout stage 1 registers the active flag, the cell address and the in-cell offsets.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_s1_act  <= 1'b0;
         r_s1_addr <= '0;
         r_s1_px   <= '0;
         r_s1_py   <= '0;
      end else begin
         r_s1_act  <= w_act;
         r_s1_addr <= w_act ? f_addr(w_row, w_col) : '0;
         r_s1_px   <= w_px[PXW-1:0];
         r_s1_py   <= w_py[PYW-1:0];
      end
   end

   // Scanout stage 2 reads the RAM and blanks every output outside the active area.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_char_code <= 8'h00;
         r_cell_px   <= '0;
         r_cell_py   <= '0;
         r_pix_act   <= 1'b0;
      end else if (r_s1_act) begin
         r_char_code <= r_mem[r_s1_addr];
         r_cell_px   <= r_s1_px;
         r_cell_py   <= r_s1_py;
         r_pix_act   <= 1'b1;
      end else begin
         r_char_code <= 8'h00;
         r_cell_px   <= '0;
         r_cell_py   <= '0;
         r_pix_act   <= 1'b0;
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int FW = $clog2(BLINK_FR + 1);

   logic [FW-1:0] r_frame_cnt;
   logic          r_phase;
   logic [XW-1:0] r_s1_col;
   logic [YW-1:0] r_s1_row;
   logic          r_cur_hit;

   // Count frame starts and toggle the blink phase every BLINK_FR frames. The phase starts on.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_frame_cnt <= '0;
         r_phase     <= 1'b1;
      end else if ((hc == 10'd0) && (vc == 10'd0)) begin
         if (r_frame_cnt == FW'(BLINK_FR - 1)) begin
            r_frame_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   // Carry the cell coordinates alongside the address, so the cursor compare lines up with char_code.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_s1_col  <= '0;
         r_s1_row  <= '0;
         r_cur_hit <= 1'b0;
      end else begin
         r_s1_col  <= w_col;
         r_s1_row  <= w_row;
         r_cur_hit <= r_s1_act && (r_s1_col == r_cur_x) && (r_s1_row == r_cur_y) && r_phase;
      end
   end

   assign cur_hit = r_cur_hit;
`else
   assign cur_hit = 1'b0;
`endif

   assign busy      = r_busy;
   assign cur_x     = r_cur_x;
   assign cur_y     = r_cur_y;
   assign char_code = r_char_code;
   assign cell_px   = r_cell_px;
   assign cell_py   = r_cell_py;
   assign pix_act   = r_pix_act;

endmodule
